// File: rtl/elevator_call_scheduler.sv
// Elevator call scheduler: latches hall/in-car button presses as pending calls,
// clears them when the car is seen serving the floor, and raises a park request
// to floor 1 after the car has sat idle away from floor 1 for IDLE_CYCLES cycles.
module elevator_call_scheduler #(
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] press_up,
    input  logic [2:0] press_down,
    input  logic [3:0] press_in,
    input  logic [2:0] position,
    input  logic       open,
    input  logic [1:0] direction,
    output logic [2:0] button_up,
    output logic [2:0] button_down,
    output logic [3:0] button_in,
    output logic       parking,
    output logic       pending
);

    typedef enum logic {
        ST_IDLE,
        ST_PARK
    } state_e;

    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_CYCLES);

    state_e           state_q, state_d;
    logic [2:0]       up_q, up_d;
    logic [2:0]       down_q, down_d;
    logic [3:0]       in_q, in_d;
    logic             park_q, park_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       serve;
    logic       dir_up, dir_down;
    logic [1:0] floor;
    logic [2:0] clr_up, clr_down;
    logic [3:0] clr_in;
    logic       any_press;
    logic       idle_cond;
    logic       park_served;
    logic       user_pending;

    // Decode which call bits the car is serving this cycle.
    always_comb begin
        serve    = open & ~position[0];
        floor    = position[2:1];
        dir_up   = (direction == 2'b01);
        dir_down = (direction == 2'b10);
        clr_up   = '0;
        clr_down = '0;
        clr_in   = '0;
        if (serve) begin
            clr_in[floor] = 1'b1;
            case (floor)
                2'd0: clr_up[0] = ~dir_down;
                2'd1: begin
                    clr_up[1]   = ~dir_down;
                    clr_down[0] = ~dir_up;
                end
                2'd2: begin
                    clr_up[2]   = ~dir_down;
                    clr_down[1] = ~dir_up;
                end
                default: clr_down[2] = ~dir_up;
            endcase
        end
    end

    // Next-state for call bits, idle counter and park state machine.
    always_comb begin
        user_pending = |{up_q, down_q, in_q};
        any_press    = |{press_up, press_down, press_in};
        park_served  = open & (position == 3'b000);
        idle_cond    = ~user_pending & ~open & ~dir_up & ~dir_down &
                       (position != 3'b000) & (state_q == ST_IDLE);

        // Clear has priority over a same-cycle press on the served bit.
        up_d   = (up_q   | press_up)   & ~clr_up;
        down_d = (down_q | press_down) & ~clr_down;
        in_d   = (in_q   | press_in)   & ~clr_in;

        state_d = state_q;
        park_d  = park_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!idle_cond) begin
                    cnt_d = '0;
                end else if (cnt_q == IDLE_MAX) begin
                    // A press arriving at the threshold holds the count
                    // instead of parking; the new call then resets it.
                    if (!any_press) begin
                        state_d = ST_PARK;
                        park_d  = 1'b1;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
                if (any_press || park_served) begin
                    state_d = ST_IDLE;
                    park_d  = 1'b0;
                end
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            up_q    <= '0;
            down_q  <= '0;
            in_q    <= '0;
            park_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            up_q    <= up_d;
            down_q  <= down_d;
            in_q    <= in_d;
            park_q  <= park_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are pure functions of registers.
    always_comb begin
        button_up   = up_q;
        button_down = down_q;
        button_in   = in_q | {3'b000, park_q};
        parking     = park_q;
        pending     = |{up_q, down_q, in_q};
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed self-checking bench for elevator_call_scheduler (IDLE_CYCLES=4).
module tb_elevator_call_scheduler;

    logic       clk;
    logic       reset_n;
    logic [2:0] press_up, press_down;
    logic [3:0] press_in;
    logic [2:0] position;
    logic       open;
    logic [1:0] direction;
    logic [2:0] button_up, button_down;
    logic [3:0] button_in;
    logic       parking, pending;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    elevator_call_scheduler #(
        .IDLE_CYCLES(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .press_up(press_up),
        .press_down(press_down),
        .press_in(press_in),
        .position(position),
        .open(open),
        .direction(direction),
        .button_up(button_up),
        .button_down(button_down),
        .button_in(button_in),
        .parking(parking),
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] up, input logic [2:0] dn,
                              input logic [3:0] inb, input logic pk, input logic pd);
        check_val({tag, ".up"},   32'(button_up),   32'(up));
        check_val({tag, ".down"}, 32'(button_down), 32'(dn));
        check_val({tag, ".in"},   32'(button_in),   32'(inb));
        check_val({tag, ".park"}, 32'(parking),     32'(pk));
        check_val({tag, ".pend"}, 32'(pending),     32'(pd));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_press();
        press_up   = '0;
        press_down = '0;
        press_in   = '0;
    endtask

    initial begin
        reset_n   = 1'b1;
        clear_press();
        position  = 3'b000;
        open      = 1'b0;
        direction = 2'b00;
        #1 reset_n = 1'b0;
        step();
        step();
        check_outs("reset", 3'b000, 3'b000, 4'b0000, 1'b0, 1'b0);
        reset_n = 1'b1;
        step();

        // In-car press for floor 3, then serve it.
        press_in = 4'b0100;
        step();
        clear_press();
        check_outs("t1_set", 3'b000, 3'b000, 4'b0100, 1'b0, 1'b1);
        position = 3'b100;
        open     = 1'b1;
        step();
        check_outs("t1_clr", 3'b000, 3'b000, 4'b0000, 1'b0, 1'b0);
        open = 1'b0; position = 3'b000;

        // Floor 2 up and down calls, direction-dependent clearing.
        press_up = 3'b010; press_down = 3'b001;
        step();
        clear_press();
        check_outs("t2_set", 3'b010, 3'b001, 4'b0000, 1'b0, 1'b1);
        position = 3'b010; open = 1'b1; direction = 2'b01;
        step();
        check_outs("t2_dirup", 3'b000, 3'b001, 4'b0000, 1'b0, 1'b1);
        direction = 2'b00;
        step();
        check_outs("t2_stop", 3'b000, 3'b000, 4'b0000, 1'b0, 1'b0);
        open = 1'b0; position = 3'b000;

        // All calls set, car between floors: nothing clears.
        press_up = 3'b111; press_down = 3'b111; press_in = 4'b1111;
        position = 3'b011;
        step();
        clear_press();
        for (int i = 0; i < 5; i++) begin
            check_outs("t3_hold", 3'b111, 3'b111, 4'b1111, 1'b0, 1'b1);
            step();
        end
        open = 1'b1; position = 3'b000;
        step();
        position = 3'b010;
        step();
        check_outs("t3_f2", 3'b100, 3'b110, 4'b1100, 1'b0, 1'b1);
        position = 3'b100;
        step();
        position = 3'b110;
        step();
        check_outs("t3_f4", 3'b000, 3'b000, 4'b0000, 1'b0, 1'b0);
        open = 1'b0; position = 3'b000;

        // Press on the floor being served: clear wins; other floor latches.
        open = 1'b1;
        press_up = 3'b011;
        step();
        clear_press();
        check_outs("t4_clrwin", 3'b010, 3'b000, 4'b0000, 1'b0, 1'b1);
        position = 3'b010;
        step();
        check_outs("t4_clr2", 3'b000, 3'b000, 4'b0000, 1'b0, 1'b0);
        open = 1'b0; position = 3'b000;
        step();

        // Idle at floor 3: park after exactly 5 cycles, then complete at floor 1.
        position = 3'b100;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("t5_notyet", 32'(parking), 32'd0);
        end
        step();
        check_outs("t5_park", 3'b000, 3'b000, 4'b0001, 1'b1, 1'b0);
        position = 3'b000; open = 1'b1;
        step();
        check_outs("t5_done", 3'b000, 3'b000, 4'b0000, 1'b0, 1'b0);
        open = 1'b0;

        // Re-park, then a hall press cancels parking.
        position = 3'b100;
        repeat (5) step();
        check_val("t6_park", 32'(parking), 32'd1);
        press_down = 3'b100;
        step();
        clear_press();
        check_outs("t6_cancel", 3'b000, 3'b100, 4'b0000, 1'b0, 1'b1);
        position = 3'b110; open = 1'b1;
        step();
        check_outs("t6_served", 3'b000, 3'b000, 4'b0000, 1'b0, 1'b0);
        open = 1'b0; position = 3'b100;
        repeat (5) step();
        check_val("t6_repark", 32'(parking), 32'd1);

        // Reset mid-PARK drops everything immediately, then restarts counting from 0.
        #2 reset_n = 1'b0;
        #1;
        check_outs("t6_rst", 3'b000, 3'b000, 4'b0000, 1'b0, 1'b0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("t6_rst_cnt", 32'(parking), 32'd0);
        end
        step();
        check_val("t6_rst_park", 32'(parking), 32'd1);

        // In-car floor 1 press while parked becomes a user call.
        press_in = 4'b0001;
        step();
        clear_press();
        check_outs("t6_in0", 3'b000, 3'b000, 4'b0001, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
Registers user call presses (hall up/down, in-car) as pending calls and drives the `button_up`/`button_down`/`button_in` level inputs of the elevator controller. Clears each call when the elevator's `position`/`open`/`direction` show it has been served. An idle-park state machine returns an idle car to floor 1 after a programmable timeout. Sits between the push-button pad interface and the elevator controller, and is fed back from the controller's registered outputs.

Parameters:
IDLE_CYCLES, 16, consecutive idle cycles before a park request is raised (1..2^CNT_W-1)
CNT_W, 8, width of the idle counter

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
press_up  input  3  one-cycle press pulses; [0] floor1, [1] floor2, [2] floor3 up
press_down  input  3  one-cycle press pulses; [0] floor2, [1] floor3, [2] floor4 down
press_in  input  4  one-cycle in-car press pulses; [0]..[3] floors 1..4
position  input  3  elevator position; even codes are at a floor (`position[2:1]` = floor-1), odd codes are between floors
open  input  1  elevator door state, 1 = open
direction  input  2  00 stop, 01 up, 10 down (11 never driven; treat as 00)
button_up  output  3  pending up calls to elevator, same indexing as press_up
button_down  output  3  pending down calls, same indexing as press_down
button_in  output  4  pending in-car calls, OR park request on [0]
parking  output  1  1 while an idle-park request is outstanding
pending  output  1  OR of all user-originated pending call bits (park bit excluded)

Behaviour:
- All state is in registers. Every output is a registered value or a pure function of registers.
- Reset (`reset_n`=0, asynchronous): all call bits 0, park bit 0, state IDLE, idle counter 0. Every output is therefore 0.
- Latency: a press pulse in cycle N appears on the outputs after the clk edge ending cycle N, i.e. one cycle.
- Set rule: a call bit is set by its press pulse and holds until cleared. A repeated press on a set bit has no effect.
- Serving condition: `open`=1 and `position[0]`=0. Served floor f = `position[2:1]`.
- Clear rule, while the serving condition holds:
  - clear `in[f]` always;
  - clear `up` of floor f if `direction` is not 10;
  - clear `down` of floor f if `direction` is not 01.
  - Floor 4 has no up bit and floor 1 has no down bit.
- Same-cycle press and clear on the same bit: clear wins, because the call is being served with the door open.
- While `position[0]`=1 (between floors), nothing is cleared.
- Idle counter:
  - Counts while all of the following hold: `pending`=0, `open`=0, `direction`=00, `position`≠000, state IDLE.
  - Resets to 0 whenever any of these is false.
  - Saturates at IDLE_CYCLES; never wraps.
- State machine IDLE/PARK:
  - IDLE→PARK when the counter reaches IDLE_CYCLES. Set park bit, `parking`=1; counter cleared.
  - PARK→IDLE when any press pulse arrives. Park bit cleared in the same edge, unless `press_in[0]` is the press, in which case `in[0]` is set as a user call.
  - PARK→IDLE when the floor-1 serving condition holds (`position`=000, `open`=1). Park bit cleared.
  - Press and park-completion in the same cycle: go to IDLE, park bit cleared, new press bits set per the set and clear rules.
- `button_in[0]` = `in[0]` OR park bit.
- Reset asserted mid-operation drops all calls immediately. After deassertion, operation restarts from IDLE with a zero counter.

Test Plan:
1. Reset, then `press_in`=0100 for 1 cycle with `position`=000 -> next cycle `button_in`=0100, `pending`=1; other outputs 0.
2. `up[1]` and `down[0]` pending (both floor 2); drive `position`=010, `open`=1, `direction`=01 -> next cycle `button_up[1]`=0, `button_down[0]` still 1. Change `direction` to 00 -> `button_down[0]`=0.
3. `position`=011 (between floors), `open`=0, all calls set -> no bit clears for 5 cycles.
4. Same cycle: `press_up[0]` pulse while `position`=000, `open`=1, `direction`=00 -> `button_up[0]` stays 0.
5. IDLE_CYCLES=4, `position`=100, idle inputs -> `parking`=1 and `button_in[0]`=1 exactly 5 cycles after idle starts. Then drive `position`=000, `open`=1 -> `parking`=0, `button_in`=0000.
6. In PARK, `press_down[2]` pulse -> next cycle `parking`=0, `button_in[0]`=0, `button_down`=100. Separately, assert `reset_n`=0 mid-PARK -> all outputs 0 immediately.
